// File: rtl/arf_var_sched_pkg.sv
// ---------------------------------------------------------------------------
// arf_var_pkg
// Shared types and constants for the time-multiplexed ARF variance scheduler:
// FSM state encoding, the static schedule length, operand-source selectors,
// scratch-register indices and the schedule-entry record returned by the ROM.
// Helper functions build schedule entries so the ROM table stays readable.
// ---------------------------------------------------------------------------
package arf_var_pkg;

    localparam int ARF_DW = 16;
    localparam int ARF_AW = 32;

    localparam int NUM_STEPS = 18;
    localparam int STEP_W    = 5;

    // Scratch registers are indexed by the dataflow-graph op number so the
    // schedule reads like the graph. a27/a28 live at the top of the range.
    localparam int SCRATCH_LO = 1;
    localparam int SCRATCH_HI = 28;
    localparam logic [4:0] IDX_A27 = 5'd27;
    localparam logic [4:0] IDX_A28 = 5'd28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // ZERO is encoded as 0 so an all-zero schedule entry is an idle slot.
    typedef enum logic [2:0] {
        SRC_ZERO = 3'd0,
        SRC_IN   = 3'd1,
        SRC_M    = 3'd2,
        SRC_A    = 3'd3,
        SRC_C13  = 3'd4,
        SRC_C14  = 3'd5,
        SRC_KC   = 3'd6,
        SRC_NEG  = 3'd7
    } src_kind_e;

    // For SRC_IN, idx is the sample number minus one (0..7); for SRC_M and
    // SRC_A it is the scratch index (op number).
    typedef struct packed {
        src_kind_e  kind;
        logic [4:0] idx;
    } src_t;

    typedef struct packed {
        logic       mul_en;
        src_t       mul_a_sel;
        src_t       mul_b_sel;
        logic [4:0] mul_dst;
        logic       add_en;
        src_t       add_a_sel;
        src_t       add_b_sel;
        logic [4:0] add_dst;
    } sched_entry_t;

    localparam src_t KC_SRC  = '{kind: SRC_KC,  idx: 5'd0};
    localparam src_t NEG_SRC = '{kind: SRC_NEG, idx: 5'd0};
    localparam src_t C13_SRC = '{kind: SRC_C13, idx: 5'd0};
    localparam src_t C14_SRC = '{kind: SRC_C14, idx: 5'd0};

    function automatic src_t in_src(input int k);
        src_t s;
        s.kind = SRC_IN;
        s.idx  = 5'(k - 1);
        return s;
    endfunction

    function automatic src_t m_src(input int k);
        src_t s;
        s.kind = SRC_M;
        s.idx  = 5'(k);
        return s;
    endfunction

    function automatic src_t a_src(input int k);
        src_t s;
        s.kind = SRC_A;
        s.idx  = 5'(k);
        return s;
    endfunction

    function automatic sched_entry_t mul_slot(input src_t a, input src_t b, input int dst);
        sched_entry_t e;
        e           = '0;
        e.mul_en    = 1'b1;
        e.mul_a_sel = a;
        e.mul_b_sel = b;
        e.mul_dst   = 5'(dst);
        return e;
    endfunction

    function automatic sched_entry_t add_slot(input src_t a, input src_t b, input int dst);
        sched_entry_t e;
        e           = '0;
        e.add_en    = 1'b1;
        e.add_a_sel = a;
        e.add_b_sel = b;
        e.add_dst   = 5'(dst);
        return e;
    endfunction

endpackage

// File: rtl/arf_var_sched_if.sv
// ---------------------------------------------------------------------------
// arf_var_sched_if
// Request/response bundle of the ARF variance scheduler.
//   start          request, accepted when the block is not busy
//   in_1..in_8     16-bit samples, captured on accept
//   c13, c14       32-bit constant addends, captured on accept
//   busy           high while the schedule is executing
//   done           one-cycle pulse when out_27/out_28 are updated
//   out_27, out_28 32-bit results, held until the next done
// master: the requester; slave: the scheduler.
// ---------------------------------------------------------------------------
interface arf_var_sched_if;
    import arf_var_pkg::*;

    logic              start;
    logic [ARF_DW-1:0] in_1;
    logic [ARF_DW-1:0] in_2;
    logic [ARF_DW-1:0] in_3;
    logic [ARF_DW-1:0] in_4;
    logic [ARF_DW-1:0] in_5;
    logic [ARF_DW-1:0] in_6;
    logic [ARF_DW-1:0] in_7;
    logic [ARF_DW-1:0] in_8;
    logic [ARF_AW-1:0] c13;
    logic [ARF_AW-1:0] c14;
    logic              busy;
    logic              done;
    logic [ARF_AW-1:0] out_27;
    logic [ARF_AW-1:0] out_28;

    modport master (
        output start, in_1, in_2, in_3, in_4, in_5, in_6, in_7, in_8, c13, c14,
        input  busy, done, out_27, out_28
    );

    modport slave (
        input  start, in_1, in_2, in_3, in_4, in_5, in_6, in_7, in_8, c13, c14,
        output busy, done, out_27, out_28
    );

endinterface

// File: rtl/arf_var_sched_rom.sv
// ---------------------------------------------------------------------------
// arf_var_sched_rom
// Combinational lookup of the 18-step static schedule. Each entry names at
// most one multiply and one add, their operand sources and destinations.
// Steps outside 0..17 return an all-idle entry.
//   step   in   current schedule step
//   entry  out  schedule entry for that step
// ---------------------------------------------------------------------------
module arf_var_sched_rom
    import arf_var_pkg::*;
(
    input  logic [STEP_W-1:0] step,
    output sched_entry_t      entry
);

    // Every add consumes only results registered in earlier steps; the table
    // is ordered so that holds for each row.
    always_comb begin
        entry = '0;
        case (step)
            5'd0:  entry = mul_slot(in_src(1), KC_SRC, 1);
            5'd1:  entry = mul_slot(in_src(2), KC_SRC, 2);
            5'd2:  entry = sched_entry_t'(mul_slot(in_src(3), KC_SRC, 3)
                                        | add_slot(m_src(1), m_src(2), 9));
            5'd3:  entry = mul_slot(in_src(4), KC_SRC, 4);
            5'd4:  entry = sched_entry_t'(mul_slot(in_src(5), KC_SRC, 5)
                                        | add_slot(m_src(3), m_src(4), 10));
            5'd5:  entry = sched_entry_t'(mul_slot(in_src(6), KC_SRC, 6)
                                        | add_slot(a_src(10), C13_SRC, 13));
            5'd6:  entry = sched_entry_t'(mul_slot(in_src(7), KC_SRC, 7)
                                        | add_slot(m_src(5), m_src(6), 11));
            5'd7:  entry = sched_entry_t'(mul_slot(in_src(8), KC_SRC, 8)
                                        | add_slot(a_src(11), C14_SRC, 14));
            5'd8:  entry = sched_entry_t'(mul_slot(a_src(13), KC_SRC, 15)
                                        | add_slot(m_src(7), m_src(8), 12));
            5'd9:  entry = mul_slot(a_src(14), KC_SRC, 16);
            5'd10: entry = sched_entry_t'(mul_slot(a_src(13), KC_SRC, 17)
                                        | add_slot(m_src(15), m_src(16), 19));
            5'd11: entry = mul_slot(a_src(14), KC_SRC, 18);
            5'd12: entry = sched_entry_t'(mul_slot(a_src(19), NEG_SRC, 21)
                                        | add_slot(m_src(17), m_src(18), 20));
            5'd13: entry = mul_slot(a_src(20), NEG_SRC, 22);
            5'd14: entry = sched_entry_t'(mul_slot(a_src(19), NEG_SRC, 23)
                                        | add_slot(m_src(21), m_src(22), 25));
            5'd15: entry = sched_entry_t'(mul_slot(a_src(20), KC_SRC, 24)
                                        | add_slot(a_src(9), a_src(25), 27));
            5'd16: entry = add_slot(m_src(23), m_src(24), 26);
            5'd17: entry = add_slot(a_src(12), a_src(26), 28);
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/arf_var_sched.sv
// ---------------------------------------------------------------------------
// arf_var_sched
// Low-area evaluator of the 28-op ARF variance dataflow graph. One shared
// 16x16->32 multiplier and one shared 32-bit adder are driven by an 18-step
// static schedule; intermediate results live in scratch registers indexed
// by op number.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave side of arf_var_sched_if (start/inputs in, busy/done/results out)
// Timing: accept in cycle 0, steps 0..17 in cycles 1..18, done in cycle 19.
// ---------------------------------------------------------------------------
module arf_var_sched
    import arf_var_pkg::*;
#(
    parameter int DW = ARF_DW,
    parameter int AW = ARF_AW,
    parameter int KC = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    arf_var_sched_if.slave bus
);

    localparam logic [DW-1:0]     KC_VAL    = DW'(KC);
    localparam logic [DW-1:0]     NEG_VAL   = ~KC_VAL + {{(DW-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    state_e            state;
    state_e            state_nxt;
    logic [STEP_W-1:0] step;
    logic              accept;
    logic              run_step;
    logic              last_step;
    logic              busy;
    logic              done;

    logic [DW-1:0]     in_reg  [0:7];
    logic [AW-1:0]     c13_reg;
    logic [AW-1:0]     c14_reg;
    logic [AW-1:0]     scratch [SCRATCH_LO:SCRATCH_HI];
    logic [AW-1:0]     out_27_q;
    logic [AW-1:0]     out_28_q;

    sched_entry_t      entry;
    logic [DW-1:0]     mul_a;
    logic [DW-1:0]     mul_b;
    logic [AW-1:0]     mul_res;
    logic [AW-1:0]     add_a;
    logic [AW-1:0]     add_b;
    logic [AW-1:0]     add_res;

    arf_var_sched_rom u_rom (
        .step  (step),
        .entry (entry)
    );

    // Multiplier operands take only the low DW bits of any 32-bit source,
    // which is what drops the carry bits of a13/a14/a19/a20.
    function automatic logic [DW-1:0] fetch_mul(input src_t s);
        logic [DW-1:0] v;
        case (s.kind)
            SRC_IN:       v = in_reg[s.idx[2:0]];
            SRC_M, SRC_A: v = scratch[s.idx][DW-1:0];
            SRC_C13:      v = c13_reg[DW-1:0];
            SRC_C14:      v = c14_reg[DW-1:0];
            SRC_KC:       v = KC_VAL;
            SRC_NEG:      v = NEG_VAL;
            default:      v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [AW-1:0] fetch_add(input src_t s);
        logic [AW-1:0] v;
        case (s.kind)
            SRC_IN:       v = AW'(in_reg[s.idx[2:0]]);
            SRC_M, SRC_A: v = scratch[s.idx];
            SRC_C13:      v = c13_reg;
            SRC_C14:      v = c14_reg;
            SRC_KC:       v = AW'(KC_VAL);
            SRC_NEG:      v = AW'(NEG_VAL);
            default:      v = '0;
        endcase
        return v;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. DONE accepts a new start exactly like IDLE, which
    // allows back-to-back runs without an idle cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.start ? RUN : IDLE;
            RUN:     state_nxt = (step == LAST_STEP) ? DONE : RUN;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/control decode; start during RUN is simply not accepted.
    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        accept    = bus.start && (state != RUN);
        run_step  = (state == RUN);
        last_step = (state == RUN) && (step == LAST_STEP);
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.out_27 = out_27_q;
    assign bus.out_28 = out_28_q;

    // Shared units; an idle slot in the schedule selects zero operands.
    always_comb begin
        mul_a   = fetch_mul(entry.mul_a_sel);
        mul_b   = fetch_mul(entry.mul_b_sel);
        add_a   = fetch_add(entry.add_a_sel);
        add_b   = fetch_add(entry.add_b_sel);
        mul_res = AW'(mul_a) * AW'(mul_b);
        add_res = add_a + add_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= '0;
        end else if (accept) begin
            step <= '0;
        end else if (run_step) begin
            step <= step + STEP_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                in_reg[i] <= '0;
            end
            c13_reg <= '0;
            c14_reg <= '0;
        end else if (accept) begin
            in_reg[0] <= bus.in_1;
            in_reg[1] <= bus.in_2;
            in_reg[2] <= bus.in_3;
            in_reg[3] <= bus.in_4;
            in_reg[4] <= bus.in_5;
            in_reg[5] <= bus.in_6;
            in_reg[6] <= bus.in_7;
            in_reg[7] <= bus.in_8;
            c13_reg   <= bus.c13;
            c14_reg   <= bus.c14;
        end
    end

    // Results of a step land in scratch at the end of that step, so later
    // steps see them and the same step never does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = SCRATCH_LO; i <= SCRATCH_HI; i++) begin
                scratch[i] <= '0;
            end
        end else if (run_step) begin
            if (entry.mul_en) begin
                scratch[entry.mul_dst] <= mul_res;
            end
            if (entry.add_en) begin
                scratch[entry.add_dst] <= add_res;
            end
        end
    end

    // a27 is computed two steps early but held in scratch so both outputs
    // change together on the edge into DONE; a28 is taken straight from the
    // adder on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_27_q <= '0;
            out_28_q <= '0;
        end else if (last_step) begin
            out_27_q <= scratch[IDX_A27];
            out_28_q <= add_res;
        end
    end

endmodule
